dfa_lookahead_ram: RTL and testbench

DFA_LOOKAHEAD_RAM -- requirements
Module: dfa_lookahead_ram

---
 rtl/dfa_ram_pkg.sv | 30 +++
 rtl/dfa_ram_rd_port.sv | 83 ++++++++
 rtl/dfa_lookahead_ram.sv | 141 ++++++++++++++
 tb/tb_dfa_lookahead_ram.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfa_ram_pkg.sv
// -----------------------------------------------------------------------------
// dfa_ram_pkg
//   Shared definitions for the lookahead RAM:
//     clog2()      - ceiling log2 used to size address fields
//     clr_state_e  - clear FSM encoding (CLEAR sweeps zeros, READY accepts writes)
//     merge_byte() - per-byte select between stored and newly written data
// -----------------------------------------------------------------------------
package dfa_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       take_new);
    return take_new ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dfa_ram_rd_port.sv
// -----------------------------------------------------------------------------
// dfa_ram_rd_port
//   Output side of one read port. The raw array word (mem_q) is read
//   synchronously in the top; this block registers the port address, a valid
//   flag and a bypass flag, captures the write data/byteenable that collided
//   with the read, and muxes the final word.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   rd_address   [AW]   read address sampled at each rising edge
//   ready               clear FSM is in READY (reads return data)
//   wr_accept           a write is being accepted this cycle
//   wr_address   [AW]   write address
//   wr_writedata [DW]   write data
//   wr_be        [BE_W] effective byte enables of the write
//   mem_q        [DW]   stored word read at the same edge (pre-write value)
//   rd_readdata  [DW]   port output, valid one cycle after the address
// -----------------------------------------------------------------------------
module dfa_ram_rd_port
  import dfa_ram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 4,
  parameter int BE_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [AW-1:0]         rd_address,
  input  logic                  ready,
  input  logic                  wr_accept,
  input  logic [AW-1:0]         wr_address,
  input  logic [DATA_WIDTH-1:0] wr_writedata,
  input  logic [BE_W-1:0]       wr_be,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] rd_readdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0]         addr_q;
  logic                  vld_q;
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic [BE_W-1:0]       byp_be_q;
  logic                  addr_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      vld_q  <= 1'b0;
      byp_q  <= 1'b0;
    end else begin
      addr_q <= rd_address;
      vld_q  <= ready;
      // wr_accept already implies READY and an in-range address.
      byp_q  <= wr_accept && (wr_address == rd_address);
    end
  end

  // Payload only matters when byp_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      byp_data_q <= wr_writedata;
      byp_be_q   <= wr_be;
    end
  end

  assign addr_ok = ({1'b0, addr_q} < DEPTH_W);

  // mem_q holds the word as it was before the colliding write, so merging the
  // captured enabled bytes over it yields the post-write word.
  always_comb begin
    rd_readdata = '0;
    if (vld_q && addr_ok) begin
      for (int b = 0; b < BE_W; b++) begin
        rd_readdata[b*8 +: 8] = merge_byte(mem_q[b*8 +: 8], byp_data_q[b*8 +: 8],
                                           byp_q && byp_be_q[b]);
      end
    end
  end

endmodule

// File: rtl/dfa_lookahead_ram.sv
// -----------------------------------------------------------------------------
// dfa_lookahead_ram
//   Single-write, multi-read RAM with 1-cycle read latency and write-to-read
//   lookahead: a read of the address being written in the same cycle returns
//   the new data. Optional zero sweep after reset (CLEAR_ON_RESET=1).
//
//   Build option: define DFA_RAM_BYTEENABLE_EN to add wr_byteenable and make
//   writes and the bypass per-byte; otherwise every write updates the full word.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   wr_address     [AW]          write word address
//   wr_writedata   [DATA_WIDTH]  write data
//   wr_write                     write strobe
//   wr_byteenable  [BE_W]        per-byte enable (DFA_RAM_BYTEENABLE_EN only)
//   wr_waitrequest               high while writes are not accepted
//   rd_address     [NP*AW]       port p address at [p*AW +: AW]
//   rd_readdata    [NP*DW]       port p data at [p*DATA_WIDTH +: DATA_WIDTH]
//
// Handshake: a write is taken on a rising edge where wr_write=1 and
// wr_waitrequest=0 and the address is in range; anything else is dropped and
// never retried. Reads have no strobe and are sampled every edge.
// -----------------------------------------------------------------------------
module dfa_lookahead_ram
  import dfa_ram_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_RD_PORTS   = 2,
  parameter int CLEAR_ON_RESET = 0,
  localparam int AW   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  localparam int BE_W = DATA_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [AW-1:0]                        wr_address,
  input  logic [DATA_WIDTH-1:0]                wr_writedata,
  input  logic                                 wr_write,
`ifdef DFA_RAM_BYTEENABLE_EN
  input  logic [BE_W-1:0]                      wr_byteenable,
`endif
  output logic                                 wr_waitrequest,
  input  logic [NUM_RD_PORTS*AW-1:0]           rd_address,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_readdata
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_e            state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  clr_we;
  logic                  ready;
  logic                  wr_accept;
  logic [BE_W-1:0]       wr_be;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef DFA_RAM_BYTEENABLE_EN
  assign wr_be = wr_byteenable;
`else
  assign wr_be = '1;
`endif

  // Clear FSM. Without CLEAR_ON_RESET the CLEAR state lasts one cycle so that
  // wr_waitrequest drops on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= LAST_ADDR;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we = 1'b1;
          if (clr_cnt_q == '0) state_d = READY;
          else                 clr_cnt_d = clr_cnt_q - AW'(1);
        end else begin
          state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign ready          = (state_q == READY);
  assign wr_waitrequest = !ready;
  assign wr_accept      = wr_write && ready && ({1'b0, wr_address} < DEPTH_W);

  // Storage: one write port, no reset. The sweep and user writes are exclusive
  // because user writes are blocked outside READY.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_accept) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_address][b*8 +: 8] <= wr_writedata[b*8 +: 8];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]         ra;
    logic [DATA_WIDTH-1:0] mem_q;

    assign ra = rd_address[p*AW +: AW];

    // Synchronous array read; out-of-range reads are masked in the port.
    always_ff @(posedge clk) begin
      if ({1'b0, ra} < DEPTH_W) mem_q <= mem[ra];
    end

    dfa_ram_rd_port #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (AW),
      .BE_W       (BE_W)
    ) u_port (
      .clk          (clk),
      .reset_n      (reset_n),
      .rd_address   (ra),
      .ready        (ready),
      .wr_accept    (wr_accept),
      .wr_address   (wr_address),
      .wr_writedata (wr_writedata),
      .wr_be        (wr_be),
      .mem_q        (mem_q),
      .rd_readdata  (rd_readdata[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_dfa_lookahead_ram.sv
// -----------------------------------------------------------------------------
// tb_dfa_lookahead_ram
//   u0: DEPTH=16, 32-bit, 2 read ports, zero sweep after reset.
//   u1: DEPTH=12, 16-bit, 1 read port, no sweep (out-of-range addresses exist).
// -----------------------------------------------------------------------------
module tb_dfa_lookahead_ram;

`ifdef DFA_RAM_BYTEENABLE_EN
  localparam bit BE_ON = 1'b1;
`else
  localparam bit BE_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;

  logic [3:0]  w0_addr;
  logic [31:0] w0_data;
  logic        w0_we;
  logic [3:0]  w0_be;
  logic        w0_wait;
  logic [7:0]  r0_addr;
  logic [63:0] r0_data;

  logic [3:0]  w1_addr;
  logic [15:0] w1_data;
  logic        w1_we;
`ifdef DFA_RAM_BYTEENABLE_EN
  logic [1:0]  w1_be;
`endif
  logic        w1_wait;
  logic [3:0]  r1_addr;
  logic [15:0] r1_data;

  dfa_lookahead_ram #(
    .DEPTH(16), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .CLEAR_ON_RESET(1)
  ) u0 (
    .clk            (clk),
    .reset_n        (rst0_n),
    .wr_address     (w0_addr),
    .wr_writedata   (w0_data),
    .wr_write       (w0_we),
`ifdef DFA_RAM_BYTEENABLE_EN
    .wr_byteenable  (w0_be),
`endif
    .wr_waitrequest (w0_wait),
    .rd_address     (r0_addr),
    .rd_readdata    (r0_data)
  );

  dfa_lookahead_ram #(
    .DEPTH(12), .DATA_WIDTH(16), .NUM_RD_PORTS(1), .CLEAR_ON_RESET(0)
  ) u1 (
    .clk            (clk),
    .reset_n        (rst1_n),
    .wr_address     (w1_addr),
    .wr_writedata   (w1_data),
    .wr_write       (w1_we),
`ifdef DFA_RAM_BYTEENABLE_EN
    .wr_byteenable  (w1_be),
`endif
    .wr_waitrequest (w1_wait),
    .rd_address     (r1_addr),
    .rd_readdata    (r1_data)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m0 [16];
  logic [15:0] m1 [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word after a byte-enabled write: enabled bytes from new data.
  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (n & mask) | (o & ~mask);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic [3:0] ra0, input logic [3:0] ra1);
    w0_we   = we;
    w0_addr = wa;
    w0_data = wd;
    w0_be   = BE_ON ? be : 4'hF;
    r0_addr = {ra1, ra0};
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] e;

    rst0_n = 1'b0; rst1_n = 1'b0;
    drive0(1'b0, 4'd0, 32'd0, 4'hF, 4'd0, 4'd0);
    w1_we = 1'b0; w1_addr = '0; w1_data = '0; r1_addr = '0;
`ifdef DFA_RAM_BYTEENABLE_EN
    w1_be = 2'b11;
`endif
    repeat (3) tick();

    // ---------------- reset state ----------------
    check("rst_wait0", {31'd0, w0_wait}, 32'd1);
    check("rst_rd0_p0", r0_data[31:0], 32'd0);
    check("rst_rd0_p1", r0_data[63:32], 32'd0);
    check("rst_wait1", {31'd0, w1_wait}, 32'd1);
    check("rst_rd1", {16'd0, r1_data}, 32'd0);

    // ---------------- clear sweep with mid-clear reset ----------------
    // Write attempts during the sweep must be dropped.
    drive0(1'b1, 4'd5, 32'h0BAD_BEEF, 4'hF, 4'd5, 4'd5);
    rst0_n = 1'b1;
    repeat (6) tick();
    check("midclr_wait", {31'd0, w0_wait}, 32'd1);
    check("midclr_rd_p0", r0_data[31:0], 32'd0);
    check("midclr_rd_p1", r0_data[63:32], 32'd0);
    rst0_n = 1'b0;
    tick();
    rst0_n = 1'b1;
    n = 0;
    while (w0_wait && n < 100) begin
      tick();
      n++;
    end
    w0_we = 1'b0;
    check("clear_len", 32'(n), 32'd16);

    for (int a = 0; a < 16; a++) m0[a] = 32'd0;
    for (int a = 0; a < 16; a++) begin
      drive0(1'b0, 4'd0, 32'd0, 4'hF, 4'(a), 4'(15 - a));
      tick();
      check("clr_rd_p0", r0_data[31:0], 32'd0);
      check("clr_rd_p1", r0_data[63:32], 32'd0);
    end

    // ---------------- table-driven directed vectors ----------------
    vecs[0] = '{1'b1, 4'd5,  32'hDEAD_BEEF, 4'd5,  4'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 4'd0,  32'h0,         4'd5,  4'd0,  32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 4'd0,  32'h1234_5678, 4'd0,  4'd5,  32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 4'd5,  32'hCAFE_F00D, 4'd3,  4'd5,  32'h0,         32'hCAFE_F00D};
    vecs[4] = '{1'b0, 4'd0,  32'h0,         4'd5,  4'd5,  32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 4'd15, 32'hA5A5_A5A5, 4'd15, 4'd14, 32'hA5A5_A5A5, 32'h0};
    vecs[6] = '{1'b1, 4'd14, 32'h5A5A_5A5A, 4'd14, 4'd15, 32'h5A5A_5A5A, 32'hA5A5_A5A5};
    vecs[7] = '{1'b0, 4'd0,  32'h0,         4'd0,  4'd14, 32'h1234_5678, 32'h5A5A_5A5A};
    for (int i = 0; i < 8; i++) begin
      drive0(vecs[i].we, vecs[i].wa, vecs[i].wd, 4'hF, vecs[i].ra0, vecs[i].ra1);
      tick();
      w0_we = 1'b0;
      if (vecs[i].we) m0[vecs[i].wa] = vecs[i].wd;
      check("vec_p0", r0_data[31:0], vecs[i].e0);
      check("vec_p1", r0_data[63:32], vecs[i].e1);
    end

    // Hold: unchanged address, then a write elsewhere must not disturb it.
    drive0(1'b0, 4'd0, 32'd0, 4'hF, 4'd5, 4'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_p0", r0_data[31:0], 32'hCAFE_F00D);
    end
    drive0(1'b1, 4'd6, 32'h7777_7777, 4'hF, 4'd5, 4'd5);
    tick();
    w0_we = 1'b0;
    m0[6] = 32'h7777_7777;
    check("hold_other_wr", r0_data[63:32], 32'hCAFE_F00D);

`ifdef DFA_RAM_BYTEENABLE_EN
    // Per-byte bypass merge.
    drive0(1'b1, 4'd3, 32'h1122_3344, 4'hF, 4'd0, 4'd0);
    tick();
    drive0(1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101, 4'd3, 4'd3);
    tick();
    w0_we = 1'b0;
    m0[3] = 32'h11BB_33DD;
    check("be_merge_p0", r0_data[31:0], 32'h11BB_33DD);
    check("be_merge_p1", r0_data[63:32], 32'h11BB_33DD);
    drive0(1'b0, 4'd0, 32'd0, 4'hF, 4'd3, 4'd0);
    tick();
    check("be_stored", r0_data[31:0], 32'h11BB_33DD);
`endif

    // ---------------- random traffic vs. mirror (u0) ----------------
    for (int c = 0; c < 1000; c++) begin
      logic        we;
      logic [3:0]  wa, ra0, ra1, be;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 1));
      wa  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      be  = BE_ON ? 4'($urandom_range(0, 15)) : 4'hF;
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      drive0(we, wa, wd, be, ra0, ra1);
      // Lookahead: a read sees the memory after this cycle's write.
      if (we) m0[wa] = merge32(m0[wa], wd, be);
      exp_q.push_back(m0[ra0]);
      exp_q.push_back(m0[ra1]);
      tick();
      e = exp_q.pop_front();
      check("rand0_p0", r0_data[31:0], e);
      e = exp_q.pop_front();
      check("rand0_p1", r0_data[63:32], e);
    end
    w0_we = 1'b0;

    // ---------------- u1: no-sweep reset, out-of-range ----------------
    rst1_n = 1'b1;
    n = 0;
    while (w1_wait && n < 100) begin
      tick();
      n++;
    end
    check("noclr_wait_len", 32'(n), 32'd1);

    w1_we = 1'b1; w1_addr = 4'd2; w1_data = 16'hBEEF; r1_addr = 4'd2;
    tick();
    check("u1_bypass", {16'd0, r1_data}, 32'h0000_BEEF);
    w1_addr = 4'd11; w1_data = 16'h1234; r1_addr = 4'd0;
    tick();
    w1_addr = 4'd14; w1_data = 16'hFFFF; r1_addr = 4'd14;
    tick();
    w1_we = 1'b0;
    check("u1_oor_wr_rd", {16'd0, r1_data}, 32'd0);
    r1_addr = 4'd11;
    tick();
    check("u1_rd11", {16'd0, r1_data}, 32'h0000_1234);
    r1_addr = 4'd14;
    tick();
    check("u1_oor_rd", {16'd0, r1_data}, 32'd0);

    // Writes during reset and on the release edge are dropped; contents kept.
    rst1_n = 1'b0;
    w1_we = 1'b1; w1_addr = 4'd2; w1_data = 16'h0000; r1_addr = 4'd2;
    repeat (2) tick();
    check("u1_rst_wait", {31'd0, w1_wait}, 32'd1);
    check("u1_rst_rd", {16'd0, r1_data}, 32'd0);
    rst1_n = 1'b1;
    tick();
    w1_we = 1'b0;
    check("u1_wait_fall", {31'd0, w1_wait}, 32'd0);
    tick();
    check("u1_preserved", {16'd0, r1_data}, 32'h0000_BEEF);

    // Prefill so every in-range word is known, then random traffic.
    for (int a = 0; a < 12; a++) begin
      w1_we = 1'b1; w1_addr = 4'(a); w1_data = 16'($urandom);
      m1[a] = w1_data;
      tick();
    end
    w1_we = 1'b0;
    for (int c = 0; c < 300; c++) begin
      logic [3:0]  wa, ra;
      logic [15:0] wd;
      logic        we;
      we = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = 16'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      w1_we = we; w1_addr = wa; w1_data = wd; r1_addr = ra;
      if (we && wa < 12) m1[wa] = wd;
      exp_q.push_back((ra < 12) ? {16'd0, m1[ra]} : 32'd0);
      tick();
      e = exp_q.pop_front();
      check("rand1", {16'd0, r1_data}, e);
    end
    w1_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
